// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline control blocks.
package mips_pkg;

  // Comparator operand source selects
  localparam logic [1:0] FWD_RF    = 2'b00;  // register file read value
  localparam logic [1:0] FWD_EXMEM = 2'b01;  // ALU result held in EX/MEM

  // Branch controller states
  typedef enum logic {
    IDLE  = 1'b0,
    STALL = 1'b1
  } brState_t;

endpackage

// File: rtl/branch_hazard_detect.sv
// Combinational hazard check for the ID-stage branch operands: how many
// stall cycles are needed and which comparator inputs take the EX/MEM value.
module branch_hazard_detect
  import mips_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] idRs,
  input  logic [REG_ADDR_W-1:0] idRt,
  input  logic                  exRegWrite,
  input  logic                  exMemRead,
  input  logic [REG_ADDR_W-1:0] exRd,
  input  logic                  memRegWrite,
  input  logic                  memMemRead,
  input  logic [REG_ADDR_W-1:0] memRd,
  output logic [1:0]            need,
  output logic [1:0]            fwdASel,
  output logic [1:0]            fwdBSel
);

  logic exHit;
  logic memHit;
  logic memAluToRs;
  logic memAluToRt;

  // Producer matches; register 0 is hard-wired and never a dependency
  always_comb begin
    exHit      = exRegWrite && (exRd != '0) && ((exRd == idRs) || (exRd == idRt));
    memHit     = memRegWrite && (memRd != '0) && ((memRd == idRs) || (memRd == idRt));
    memAluToRs = memRegWrite && !memMemRead && (memRd != '0) && (memRd == idRs);
    memAluToRt = memRegWrite && !memMemRead && (memRd != '0) && (memRd == idRt);
  end

  // Stall requirement (largest wins) and forwarding selects. A result in EX
  // is not yet in EX/MEM and a load in MEM has no data yet, so both stall;
  // only a MEM-stage ALU result can be forwarded to the comparator.
  always_comb begin
    need = 2'd0;
    if (exHit && exMemRead) begin
      need = 2'd2;
    end else if (exHit || (memHit && memMemRead)) begin
      need = 2'd1;
    end
    fwdASel = memAluToRs ? FWD_EXMEM : FWD_RF;
    fwdBSel = memAluToRt ? FWD_EXMEM : FWD_RF;
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// ID-stage branch controller: stalls on operand hazards, resolves beq/bne
// into pc_src / flush_ifid, and counts resolved and taken branches.
module branch_resolve_unit
  import mips_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic                  id_is_beq,
  input  logic                  id_is_bne,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  ex_reg_write,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  mem_reg_write,
  input  logic                  mem_mem_read,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic                  if_equal,
  output logic [1:0]            fwd_a_sel,
  output logic [1:0]            fwd_b_sel,
  output logic                  stall,
  output logic                  flush_ifid,
  output logic                  pc_src,
  output logic [CNT_W-1:0]      branch_cnt,
  output logic [CNT_W-1:0]      taken_cnt
);

  brState_t   stateReg, stateNext;
  logic [1:0] stallCntReg, stallCntNext;
  logic [1:0] need;
  logic [1:0] fwdA, fwdB;
  logic       br;
  logic       taken;
  logic       resolve;
  logic       stallInt, flushInt, pcSrcInt;
  logic [CNT_W-1:0] branchCntReg, takenCntReg;

  branch_hazard_detect #(
    .REG_ADDR_W(REG_ADDR_W)
  ) hazardDetect (
    .idRs       (id_rs),
    .idRt       (id_rt),
    .exRegWrite (ex_reg_write),
    .exMemRead  (ex_mem_read),
    .exRd       (ex_rd),
    .memRegWrite(mem_reg_write),
    .memMemRead (mem_mem_read),
    .memRd      (mem_rd),
    .need       (need),
    .fwdASel    (fwdA),
    .fwdBSel    (fwdB)
  );

  // Branch decode; beq wins if both type bits are set
  always_comb begin
    br    = id_valid && (id_is_beq || id_is_bne);
    taken = id_is_beq ? if_equal : !if_equal;
  end

  // Next-state and output decode. A branch is resolved only from IDLE with
  // no outstanding hazard; otherwise the front end is held.
  always_comb begin
    stateNext    = stateReg;
    stallCntNext = stallCntReg;
    stallInt     = 1'b0;
    flushInt     = 1'b0;
    pcSrcInt     = 1'b0;
    resolve      = 1'b0;
    case (stateReg)
      IDLE: begin
        if (br) begin
          if (need == 2'd0) begin
            resolve  = 1'b1;
            pcSrcInt = taken;
            flushInt = taken;
          end else begin
            stallInt     = 1'b1;
            stallCntNext = need - 2'd1;
            if (need == 2'd2) begin
              stateNext = STALL;
            end
          end
        end
      end
      STALL: begin
        // The last remaining stall cycle hands back to IDLE so the branch is
        // re-checked on the very next cycle with no dead cycle in between.
        if (stallCntReg != 2'd0) begin
          stallInt     = 1'b1;
          stallCntNext = stallCntReg - 2'd1;
        end
        if (stallCntReg <= 2'd1) begin
          stateNext = IDLE;
        end
      end
      default: begin
        stateNext    = IDLE;
        stallCntNext = 2'd0;
      end
    endcase
  end

  // Control outputs are forced low while reset is held
  always_comb begin
    stall      = rst_n && stallInt;
    flush_ifid = rst_n && flushInt;
    pc_src     = rst_n && pcSrcInt;
    fwd_a_sel  = (rst_n && br) ? fwdA : FWD_RF;
    fwd_b_sel  = (rst_n && br) ? fwdB : FWD_RF;
    branch_cnt = branchCntReg;
    taken_cnt  = takenCntReg;
  end

  // FSM state and stall countdown
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateReg    <= IDLE;
      stallCntReg <= 2'd0;
    end else begin
      stateReg    <= stateNext;
      stallCntReg <= stallCntNext;
    end
  end

  // Saturating statistics counters, updated on each resolution
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branchCntReg <= '0;
      takenCntReg  <= '0;
    end else if (resolve) begin
      if (branchCntReg != '1) begin
        branchCntReg <= branchCntReg + 1'b1;
      end
      if (taken && (takenCntReg != '1)) begin
        takenCntReg <= takenCntReg + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: vector table, hand sequences
// for multi-cycle cases, and random stimulus against a behavioural model.
module tb_branch_resolve_unit;

  logic       clk;
  logic       rst_n;
  logic       id_valid, id_is_beq, id_is_bne;
  logic [4:0] id_rs, id_rt;
  logic       ex_reg_write, ex_mem_read;
  logic [4:0] ex_rd;
  logic       mem_reg_write, mem_mem_read;
  logic [4:0] mem_rd;
  logic       if_equal;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  logic       stall, flush_ifid, pc_src;
  logic [15:0] branch_cnt, taken_cnt;
  // narrow-counter instance used to reach saturation quickly
  logic [1:0] s_fwd_a, s_fwd_b;
  logic       s_stall, s_flush, s_pc;
  logic [2:0] s_branch_cnt, s_taken_cnt;

  int total = 0;
  int bad   = 0;

  // behavioural model state
  int holdLeft = 0;
  int nBr      = 0;
  int nTk      = 0;
  bit lastStall = 0;

  branch_resolve_unit #(.REG_ADDR_W(5), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_is_beq(id_is_beq),
    .id_is_bne(id_is_bne), .id_rs(id_rs), .id_rt(id_rt),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read), .mem_rd(mem_rd),
    .if_equal(if_equal), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .stall(stall), .flush_ifid(flush_ifid), .pc_src(pc_src),
    .branch_cnt(branch_cnt), .taken_cnt(taken_cnt)
  );

  branch_resolve_unit #(.REG_ADDR_W(5), .CNT_W(3)) dutSmall (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_is_beq(id_is_beq),
    .id_is_bne(id_is_bne), .id_rs(id_rs), .id_rt(id_rt),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read), .mem_rd(mem_rd),
    .if_equal(if_equal), .fwd_a_sel(s_fwd_a), .fwd_b_sel(s_fwd_b),
    .stall(s_stall), .flush_ifid(s_flush), .pc_src(s_pc),
    .branch_cnt(s_branch_cnt), .taken_cnt(s_taken_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expectOut(input string name, input int st, input int fl,
                           input int pc, input int fa, input int fb);
    check({name, ".stall"}, int'(stall), st);
    check({name, ".flush"}, int'(flush_ifid), fl);
    check({name, ".pc_src"}, int'(pc_src), pc);
    check({name, ".fwd_a"}, int'(fwd_a_sel), fa);
    check({name, ".fwd_b"}, int'(fwd_b_sel), fb);
  endtask

  task automatic clearIn();
    id_valid = 0; id_is_beq = 0; id_is_bne = 0; id_rs = 0; id_rt = 0;
    ex_reg_write = 0; ex_mem_read = 0; ex_rd = 0;
    mem_reg_write = 0; mem_mem_read = 0; mem_rd = 0; if_equal = 0;
  endtask

  task automatic setBranch(input bit isBeq, input int rs, input int rt, input bit eq);
    id_valid = 1; id_is_beq = isBeq; id_is_bne = !isBeq;
    id_rs = 5'(rs); id_rt = 5'(rt); if_equal = eq;
  endtask

  task automatic resetDut();
    rst_n = 0;
    clearIn();
    @(posedge clk); #1;
    rst_n = 1;
    holdLeft = 0; nBr = 0; nTk = 0; lastStall = 0;
  endtask

  function automatic int sat(input int c, input int maxV);
    return (c > maxV) ? maxV : c;
  endfunction

  // Stall cycles the current ID operands require, from the hazard rules
  function automatic int refNeed();
    int n = 0;
    bit exDep, memDep;
    exDep  = ex_reg_write && ex_rd != 0 && (ex_rd == id_rs || ex_rd == id_rt);
    memDep = mem_reg_write && mem_rd != 0 && (mem_rd == id_rs || mem_rd == id_rt);
    if (exDep) n = ex_mem_read ? 2 : 1;
    if (memDep && mem_mem_read && n < 1) n = 1;
    return n;
  endfunction

  function automatic int refFwd(input logic [4:0] r);
    return (mem_reg_write && !mem_mem_read && mem_rd != 0 && mem_rd == r) ? 1 : 0;
  endfunction

  // One clock of model-checked operation; inputs are already applied
  task automatic modelCycle(input string name);
    bit br, tk, resolved;
    int need, st, fl, pc, fa, fb;
    @(negedge clk);
    br   = id_valid && (id_is_beq || id_is_bne);
    tk   = id_is_beq ? if_equal : !if_equal;
    need = refNeed();
    fa   = br ? refFwd(id_rs) : 0;
    fb   = br ? refFwd(id_rt) : 0;
    st = 0; fl = 0; pc = 0; resolved = 0;
    if (holdLeft > 0) begin
      st = 1; holdLeft--;
    end else if (br && need > 0) begin
      st = 1; holdLeft = need - 1;
    end else if (br) begin
      pc = tk; fl = tk; resolved = 1;
    end
    expectOut(name, st, fl, pc, fa, fb);
    check({name, ".branch_cnt"}, int'(branch_cnt), sat(nBr, 65535));
    check({name, ".taken_cnt"}, int'(taken_cnt), sat(nTk, 65535));
    check({name, ".small_branch_cnt"}, int'(s_branch_cnt), sat(nBr, 7));
    check({name, ".small_taken_cnt"}, int'(s_taken_cnt), sat(nTk, 7));
    if (resolved) begin
      nBr++;
      if (tk) nTk++;
    end
    lastStall = (st != 0);
    @(posedge clk); #1;
  endtask

  typedef struct {
    int valid, beq, bne, rs, rt;
    int exW, exR, exRd, memW, memR, memRd, eq;
    int st, fl, pc, fa, fb;
  } vec_t;

  vec_t vecs[14];

  initial begin
    rst_n = 0;
    clearIn();

    // ---- single-cycle vector table, each from a fresh reset ----
    //          v  beq bne rs rt exW exR exRd memW memR memRd eq  st fl pc fa fb
    vecs[0]  = '{1, 1, 0, 1, 2, 0, 0, 0, 0, 0, 0, 1,  0, 1, 1, 0, 0};
    vecs[1]  = '{1, 1, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0};
    vecs[2]  = '{1, 0, 1, 1, 2, 0, 0, 0, 0, 0, 0, 0,  0, 1, 1, 0, 0};
    vecs[3]  = '{0, 1, 0, 1, 2, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0};
    vecs[4]  = '{1, 1, 1, 1, 2, 0, 0, 0, 0, 0, 0, 1,  0, 1, 1, 0, 0};
    vecs[5]  = '{1, 1, 0, 3, 4, 1, 1, 3, 0, 0, 0, 1,  1, 0, 0, 0, 0};
    vecs[6]  = '{1, 1, 0, 1, 5, 1, 0, 5, 0, 0, 0, 1,  1, 0, 0, 0, 0};
    vecs[7]  = '{1, 1, 0, 6, 1, 0, 0, 0, 1, 1, 6, 1,  1, 0, 0, 0, 0};
    vecs[8]  = '{1, 1, 0, 7, 2, 0, 0, 0, 1, 0, 7, 1,  0, 1, 1, 1, 0};
    vecs[9]  = '{1, 0, 1, 2, 7, 0, 0, 0, 1, 0, 7, 1,  0, 0, 0, 0, 1};
    vecs[10] = '{1, 1, 0, 0, 0, 1, 0, 0, 1, 1, 0, 1,  0, 1, 1, 0, 0};
    vecs[11] = '{1, 1, 0, 1, 2, 0, 1, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0};
    vecs[12] = '{1, 1, 0, 3, 3, 0, 0, 0, 1, 0, 3, 1,  0, 1, 1, 1, 1};
    vecs[13] = '{1, 0, 0, 3, 0, 1, 1, 3, 0, 0, 0, 1,  0, 0, 0, 0, 0};

    for (int i = 0; i < 14; i++) begin
      resetDut();
      id_valid = vecs[i].valid[0]; id_is_beq = vecs[i].beq[0]; id_is_bne = vecs[i].bne[0];
      id_rs = 5'(vecs[i].rs); id_rt = 5'(vecs[i].rt);
      ex_reg_write = vecs[i].exW[0]; ex_mem_read = vecs[i].exR[0]; ex_rd = 5'(vecs[i].exRd);
      mem_reg_write = vecs[i].memW[0]; mem_mem_read = vecs[i].memR[0]; mem_rd = 5'(vecs[i].memRd);
      if_equal = vecs[i].eq[0];
      @(negedge clk);
      expectOut($sformatf("vec%0d", i), vecs[i].st, vecs[i].fl, vecs[i].pc, vecs[i].fa, vecs[i].fb);
      $display("vec%0d stall=%0d flush=%0d pc_src=%0d fwd=%0d/%0d", i, stall, flush_ifid, pc_src, fwd_a_sel, fwd_b_sel);
      @(posedge clk); #1;
    end

    // ---- beq r1,r2 taken, counters step on the edge ----
    resetDut();
    check("rst.branch_cnt", int'(branch_cnt), 0);
    check("rst.taken_cnt", int'(taken_cnt), 0);
    setBranch(1, 1, 2, 1);
    @(negedge clk);
    expectOut("beqTaken", 0, 1, 1, 0, 0);
    @(posedge clk); #1;
    clearIn();
    check("beqTaken.branch_cnt", int'(branch_cnt), 1);
    check("beqTaken.taken_cnt", int'(taken_cnt), 1);
    $display("seq beqTaken branch_cnt=%0d taken_cnt=%0d", branch_cnt, taken_cnt);

    // ---- lw r3 in EX, beq r3,r4: two stalls then not-taken resolve ----
    setBranch(1, 3, 4, 0);
    ex_reg_write = 1; ex_mem_read = 1; ex_rd = 3;
    @(negedge clk); expectOut("lwUse.c0", 1, 0, 0, 0, 0);
    @(posedge clk); #1;
    ex_reg_write = 0; ex_mem_read = 0; ex_rd = 0;
    mem_reg_write = 1; mem_mem_read = 1; mem_rd = 3;
    @(negedge clk); expectOut("lwUse.c1", 1, 0, 0, 0, 0);
    @(posedge clk); #1;
    mem_reg_write = 0; mem_mem_read = 0; mem_rd = 0;
    @(negedge clk); expectOut("lwUse.c2", 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    clearIn();
    check("lwUse.branch_cnt", int'(branch_cnt), 2);
    check("lwUse.taken_cnt", int'(taken_cnt), 1);
    $display("seq lwUse branch_cnt=%0d taken_cnt=%0d", branch_cnt, taken_cnt);

    // ---- add r5 in EX then MEM; bne r5,r0: one stall, then forward A ----
    setBranch(0, 5, 0, 0);
    ex_reg_write = 1; ex_rd = 5;
    @(negedge clk); expectOut("aluFwd.c0", 1, 0, 0, 0, 0);
    @(posedge clk); #1;
    ex_reg_write = 0; ex_rd = 0;
    mem_reg_write = 1; mem_rd = 5;
    @(negedge clk); expectOut("aluFwd.c1", 0, 1, 1, 1, 0);
    @(posedge clk); #1;
    clearIn();
    check("aluFwd.branch_cnt", int'(branch_cnt), 3);
    check("aluFwd.taken_cnt", int'(taken_cnt), 2);
    $display("seq aluFwd branch_cnt=%0d taken_cnt=%0d", branch_cnt, taken_cnt);

    // ---- reset asserted during the second stall cycle ----
    setBranch(1, 3, 4, 1);
    ex_reg_write = 1; ex_mem_read = 1; ex_rd = 3;
    @(negedge clk); expectOut("rstStall.c0", 1, 0, 0, 0, 0);
    @(posedge clk); #1;
    ex_reg_write = 0; ex_mem_read = 0; ex_rd = 0;
    mem_reg_write = 1; mem_mem_read = 1; mem_rd = 3;
    @(negedge clk); expectOut("rstStall.c1", 1, 0, 0, 0, 0);
    rst_n = 0;
    #1;
    expectOut("rstStall.inReset", 0, 0, 0, 0, 0);
    check("rstStall.branch_cnt", int'(branch_cnt), 0);
    mem_reg_write = 0; mem_mem_read = 0; mem_rd = 0;
    setBranch(1, 1, 2, 1);   // would be taken if not held in reset
    #1;
    expectOut("rstHeld", 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    rst_n = 1;
    holdLeft = 0; nBr = 0; nTk = 0;
    @(negedge clk); expectOut("rstRelease", 0, 1, 1, 0, 0);
    check("rstRelease.branch_cnt", int'(branch_cnt), 0);
    check("rstRelease.taken_cnt", int'(taken_cnt), 0);
    @(posedge clk); #1;
    clearIn();
    @(negedge clk); expectOut("idleNoBranch", 0, 0, 0, 0, 0);
    check("afterRst.branch_cnt", int'(branch_cnt), 1);
    $display("seq rstStall branch_cnt=%0d taken_cnt=%0d", branch_cnt, taken_cnt);
    @(posedge clk); #1;

    // ---- saturation: 3-bit instance pinned at 7, 16-bit keeps counting ----
    resetDut();
    for (int i = 0; i < 10; i++) begin
      setBranch(1, 1, 2, 1);
      @(posedge clk); #1;
    end
    clearIn();
    check("sat.small_branch_cnt", int'(s_branch_cnt), 7);
    check("sat.small_taken_cnt", int'(s_taken_cnt), 7);
    check("sat.branch_cnt", int'(branch_cnt), 10);
    check("sat.taken_cnt", int'(taken_cnt), 10);
    setBranch(0, 1, 2, 0);
    @(posedge clk); #1;
    clearIn();
    check("satHold.small_branch_cnt", int'(s_branch_cnt), 7);
    check("satHold.small_taken_cnt", int'(s_taken_cnt), 7);
    $display("seq sat small=%0d/%0d wide=%0d/%0d", s_branch_cnt, s_taken_cnt, branch_cnt, taken_cnt);

    // ---- random stimulus against the model ----
    resetDut();
    for (int i = 0; i < 600; i++) begin
      // a stalled branch stays in ID, as the real front end is held
      if (!lastStall) begin
        id_valid  = ($urandom_range(0, 4) != 0);
        id_is_beq = $urandom_range(0, 1) != 0;
        id_is_bne = $urandom_range(0, 1) != 0;
        id_rs     = 5'($urandom_range(0, 3));
        id_rt     = 5'($urandom_range(0, 3));
        if_equal  = $urandom_range(0, 1) != 0;
      end
      ex_reg_write  = $urandom_range(0, 1) != 0;
      ex_mem_read   = ($urandom_range(0, 2) == 0);
      ex_rd         = 5'($urandom_range(0, 3));
      mem_reg_write = $urandom_range(0, 1) != 0;
      mem_mem_read  = ($urandom_range(0, 2) == 0);
      mem_rd        = 5'($urandom_range(0, 3));
      modelCycle($sformatf("rnd%0d", i));
      if (i % 50 == 0)
        $display("rnd%0d branches=%0d taken=%0d", i, nBr, nTk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
